mac_operand_feeder: RTL and testbench
=====================================

# mac_operand_feeder

Sequencer that drives one accumulation pass of the MAC array element: on a start pulse it fetches TAPS activation/weight pairs from two synchronous-read buffers. It streams them into the MAC's a/b/sum/ce inputs, with the MAC's own registered output fed back as the running sum. It then captures the finished dot product and offers it downstream on a valid/ready handshake. It sits between the line/weight buffers and the convolution output writer, one feeder per MAC.

## Interface
- N, 16: data width of activations, weights, bias, sums
- TAPS, 9: products per pass (≥1; 9 = 3×3 kernel)
- AW, 8: buffer address width
- clk in 1: single clock, all state on rising edge
- rst in 1: reset, asynchronous, active-low (asserted at 0)
- start in 1: begin a pass; sampled only in IDLE
- base_act in AW, base_wgt in AW: first addresses, latched on accepted start
- bias in N: initial sum, latched on accepted start
- busy out 1: high from accepted start until result handshake completes
- buf_rd out 1: read strobe to both buffers
- act_addr out AW, wgt_addr out AW: buffer addresses
- act_data in N, wgt_data in N: buffer read data, valid one cycle after buf_rd
- mac_ce out 1, mac_a out N, mac_b out N, mac_sum out N: MAC operand port
- mac_out in N: MAC registered data_out
- res_data out N, res_valid out 1, res_ready in 1: result handshake

## Operation
- States: IDLE, ISSUE, LAST, DRAIN, HOLD.
- IDLE: start=1 → latch bases/bias, tap counter i=0, go ISSUE.
- ISSUE: buf_rd=1, act_addr=base_act+i, wgt_addr=base_wgt+i (mod 2^AW); i increments each cycle; after issuing i=TAPS−1 go LAST.
- mac_ce=1 in every cycle where buffer data returns (cycle after each buf_rd): mac_a=act_data, mac_b=wgt_data; mac_sum=bias on the first ce of the pass, mac_out on every later ce.
- LAST: no read, final ce cycle; go DRAIN.
- DRAIN: res_data ← mac_out, res_valid ← 1; go HOLD.
- HOLD: res_data, res_valid stable; res_valid&res_ready → res_valid ← 0, go IDLE.
- mac_ce=0 ⇒ mac_a, mac_b, mac_sum driven 0. buf_rd=0 ⇒ addresses hold last value.
- start outside IDLE is ignored (not queued). start coincident with the HOLD handshake is ignored; accepted next cycle.
- No arithmetic in the feeder; MAC wraps modulo 2^N.
- TAPS=1: ISSUE lasts one cycle, first ce uses bias.

## Timing
- Reset: state IDLE, busy, buf_rd, mac_ce, res_valid = 0; act_addr, wgt_addr, mac_a, mac_b, mac_sum, res_data = 0.
- Reset mid-pass: immediate clear as above; partial pass discarded; MAC content don't-care (next pass reseeds with bias).
- Start accepted at edge E0: buf_rd high cycles 1..TAPS, mac_ce high cycles 2..TAPS+1, res_valid high from cycle TAPS+3. Latency start→res_valid = TAPS+3 cycles (12 for TAPS=9).
- busy rises cycle 1, falls the cycle after the handshake edge.
- Throughput with res_ready tied high: one pass per TAPS+4 cycles.

## Configuration
- MAC_FEED_RELU_EN defined: DRAIN captures mac_out if its MSB is 0 (two's complement non-negative), else 0.
- Undefined: mac_out captured unmodified.
- No other behaviour or timing change.

## Structure
- Package mac_feed_pkg: state encoding localparams, default N/TAPS/AW, counter width clog2(TAPS) with minimum 1.
- One sub-module mac_feed_addr_gen: tap counter, base+i address adders, buf_rd, last-issue flag.
- FSM, operand muxing, result register stay in the top.

## Test plan
Bench pairs the feeder with the MAC in integer mode and two behavioural 1-cycle-latency buffers.
- TAPS=9, act[i]=i+1, wgt=1, bias=5 → res_data=0x0032 with res_valid at cycle 12; exactly 9 mac_ce cycles.
- bias=0xFF9C, all act=0: MAC_FEED_RELU_EN → res_data=0x0000; without it → 0xFF9C.
- res_ready low 5 cycles after res_valid, start pulsed meanwhile → res_data/res_valid stable, busy=1, start ignored; single result on release.
- rst low during cycle 4 of ISSUE → all outputs 0 immediately; next start with test 1 data → 0x0032.
- base_act=0xFE, AW=8 → act_addr sequence FE, FF, 00 … 06.
- start in the same cycle as the handshake → ignored; start next cycle → accepted, busy rises one cycle later.

Source files
------------

// File: rtl/mac_feed_pkg.sv
// Shared definitions for the MAC operand feeder: default sizes, state encoding
// and the tap-counter width helper.
package mac_feed_pkg;

   localparam int DEF_N    = 16;
   localparam int DEF_TAPS = 9;
   localparam int DEF_AW   = 8;

   localparam logic [2:0] ST_IDLE  = 3'd0;
   localparam logic [2:0] ST_ISSUE = 3'd1;
   localparam logic [2:0] ST_LAST  = 3'd2;
   localparam logic [2:0] ST_DRAIN = 3'd3;
   localparam logic [2:0] ST_HOLD  = 3'd4;

   typedef enum logic [2:0] {
      S_IDLE  = ST_IDLE,
      S_ISSUE = ST_ISSUE,
      S_LAST  = ST_LAST,
      S_DRAIN = ST_DRAIN,
      S_HOLD  = ST_HOLD
   } feed_state_t;

   // A single-tap pass still needs a one-bit counter.
   function automatic int cnt_width(input int taps);
      return (taps > 1) ? $clog2(taps) : 1;
   endfunction

endpackage

// File: rtl/mac_feed_addr_gen.sv
// Buffer read sequencer: tap counter, base+i address generation, read strobe
// and first/last issue flags for one accumulation pass.
module mac_feed_addr_gen
   import mac_feed_pkg::*;
#(
   parameter int TAPS = DEF_TAPS,
   parameter int AW   = DEF_AW
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          load,
   input  logic [AW-1:0] base_act,
   input  logic [AW-1:0] base_wgt,
   output logic          buf_rd,
   output logic [AW-1:0] act_addr,
   output logic [AW-1:0] wgt_addr,
   output logic          first_issue,
   output logic          last_issue
);

   localparam int             CW     = cnt_width(TAPS);
   localparam logic [CW-1:0]  LAST_I = CW'(TAPS - 1);

   logic [CW-1:0] tap_i;
   logic [CW-1:0] tap_nxt;
   logic [AW-1:0] base_act_q;
   logic [AW-1:0] base_wgt_q;

   assign tap_nxt     = tap_i + CW'(1);
   assign first_issue = buf_rd & (tap_i == '0);
   assign last_issue  = buf_rd & (tap_i == LAST_I);

   // Addresses are registered so they hold their last value once reads stop.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         tap_i      <= '0;
         buf_rd     <= 1'b0;
         base_act_q <= '0;
         base_wgt_q <= '0;
         act_addr   <= '0;
         wgt_addr   <= '0;
      end else if (load) begin
         tap_i      <= '0;
         buf_rd     <= 1'b1;
         base_act_q <= base_act;
         base_wgt_q <= base_wgt;
         act_addr   <= base_act;
         wgt_addr   <= base_wgt;
      end else if (buf_rd) begin
         if (last_issue) begin
            buf_rd <= 1'b0;
         end else begin
            tap_i    <= tap_nxt;
            act_addr <= base_act_q + AW'(tap_nxt);
            wgt_addr <= base_wgt_q + AW'(tap_nxt);
         end
      end
   end

endmodule

// File: rtl/mac_operand_feeder.sv
// Drives one MAC accumulation pass from two buffers and hands the dot product
// downstream. Optional feature macro: MAC_FEED_RELU_EN (clamp negative results to 0).
//
// state | meaning
// IDLE  | waiting for start
// ISSUE | buffer reads in flight, one tap per cycle
// LAST  | final MAC enable, no read
// DRAIN | capture MAC output into result register
// HOLD  | result offered until res_ready
module mac_operand_feeder
   import mac_feed_pkg::*;
#(
   parameter int N    = DEF_N,
   parameter int TAPS = DEF_TAPS,
   parameter int AW   = DEF_AW
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          start,
   input  logic [AW-1:0] base_act,
   input  logic [AW-1:0] base_wgt,
   input  logic [N-1:0]  bias,
   output logic          busy,
   output logic          buf_rd,
   output logic [AW-1:0] act_addr,
   output logic [AW-1:0] wgt_addr,
   input  logic [N-1:0]  act_data,
   input  logic [N-1:0]  wgt_data,
   output logic          mac_ce,
   output logic [N-1:0]  mac_a,
   output logic [N-1:0]  mac_b,
   output logic [N-1:0]  mac_sum,
   input  logic [N-1:0]  mac_out,
   output logic [N-1:0]  res_data,
   output logic          res_valid,
   input  logic          res_ready
);

   feed_state_t  state, state_nxt;
   logic         start_acc;
   logic         first_issue;
   logic         last_issue;
   logic         ce_q;
   logic         first_q;
   logic [N-1:0] bias_q;
   logic [N-1:0] res_nxt;

   assign start_acc = (state == S_IDLE) & start;
   assign busy      = (state != S_IDLE);

   mac_feed_addr_gen #(
      .TAPS (TAPS),
      .AW   (AW)
   ) u_addr_gen (
      .clk         (clk),
      .rst         (rst),
      .load        (start_acc),
      .base_act    (base_act),
      .base_wgt    (base_wgt),
      .buf_rd      (buf_rd),
      .act_addr    (act_addr),
      .wgt_addr    (wgt_addr),
      .first_issue (first_issue),
      .last_issue  (last_issue)
   );

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) state <= S_IDLE;
      else      state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         S_IDLE:  if (start)      state_nxt = S_ISSUE;
         S_ISSUE: if (last_issue) state_nxt = S_LAST;
         S_LAST:                  state_nxt = S_DRAIN;
         S_DRAIN:                 state_nxt = S_HOLD;
         S_HOLD:  if (res_ready)  state_nxt = S_IDLE;
         default:                 state_nxt = S_IDLE;
      endcase
   end

   // Read data lands one cycle after the strobe, so the MAC enable trails buf_rd.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         ce_q    <= 1'b0;
         first_q <= 1'b0;
         bias_q  <= '0;
      end else begin
         ce_q    <= buf_rd;
         first_q <= first_issue;
         if (start_acc) bias_q <= bias;
      end
   end

   assign mac_ce  = ce_q;
   assign mac_a   = ce_q ? act_data : '0;
   assign mac_b   = ce_q ? wgt_data : '0;
   assign mac_sum = ce_q ? (first_q ? bias_q : mac_out) : '0;

`ifdef MAC_FEED_RELU_EN
   assign res_nxt = mac_out[N-1] ? '0 : mac_out;
`else
   assign res_nxt = mac_out;
`endif

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         res_data  <= '0;
         res_valid <= 1'b0;
      end else if (state == S_DRAIN) begin
         res_data  <= res_nxt;
         res_valid <= 1'b1;
      end else if ((state == S_HOLD) && res_ready) begin
         res_valid <= 1'b0;
      end
   end

endmodule

// File: tb/tb_mac_operand_feeder.sv
// Bench for mac_operand_feeder with a behavioural integer MAC and two
// one-cycle-latency buffers; results are scoreboarded on the handshake.
module tb_mac_operand_feeder;

   localparam int N    = 16;
   localparam int TAPS = 9;
   localparam int AW   = 8;

   logic          clk = 1'b0;
   logic          rst = 1'b0;
   logic          start = 1'b0;
   logic [AW-1:0] base_act = '0;
   logic [AW-1:0] base_wgt = '0;
   logic [N-1:0]  bias = '0;
   logic          busy;
   logic          buf_rd;
   logic [AW-1:0] act_addr;
   logic [AW-1:0] wgt_addr;
   logic [N-1:0]  act_data = '0;
   logic [N-1:0]  wgt_data = '0;
   logic          mac_ce;
   logic [N-1:0]  mac_a;
   logic [N-1:0]  mac_b;
   logic [N-1:0]  mac_sum;
   logic [N-1:0]  mac_out = '0;
   logic [N-1:0]  res_data;
   logic          res_valid;
   logic          res_ready = 1'b0;

   logic [N-1:0]  act_mem [256];
   logic [N-1:0]  wgt_mem [256];

   int n_tests = 0;
   int n_fail  = 0;
   logic [N-1:0] sb_q [$];

   typedef struct {
      logic [AW-1:0] ba;
      logic [AW-1:0] bw;
      logic [N-1:0]  bias;
      int            stall;
      bit            hs_start;
      logic [N-1:0]  exp;
   } vec_t;

   vec_t vecs [6];

   mac_operand_feeder #(.N(N), .TAPS(TAPS), .AW(AW)) dut (
      .clk       (clk),
      .rst       (rst),
      .start     (start),
      .base_act  (base_act),
      .base_wgt  (base_wgt),
      .bias      (bias),
      .busy      (busy),
      .buf_rd    (buf_rd),
      .act_addr  (act_addr),
      .wgt_addr  (wgt_addr),
      .act_data  (act_data),
      .wgt_data  (wgt_data),
      .mac_ce    (mac_ce),
      .mac_a     (mac_a),
      .mac_b     (mac_b),
      .mac_sum   (mac_sum),
      .mac_out   (mac_out),
      .res_data  (res_data),
      .res_valid (res_valid),
      .res_ready (res_ready)
   );

   always #5 clk = ~clk;

   always @(posedge clk) begin
      if (buf_rd) begin
         act_data <= act_mem[act_addr];
         wgt_data <= wgt_mem[wgt_addr];
      end
      if (mac_ce) mac_out <= N'(mac_a * mac_b + mac_sum);
   end

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
      n_tests++;
      if (got !== want) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, got, want);
      end
   endtask

   task automatic chk_all_zero(input string tag);
      chk({tag, "_busy"},      32'(busy),      0);
      chk({tag, "_buf_rd"},    32'(buf_rd),    0);
      chk({tag, "_mac_ce"},    32'(mac_ce),    0);
      chk({tag, "_res_valid"}, 32'(res_valid), 0);
      chk({tag, "_act_addr"},  32'(act_addr),  0);
      chk({tag, "_wgt_addr"},  32'(wgt_addr),  0);
      chk({tag, "_mac_a"},     32'(mac_a),     0);
      chk({tag, "_mac_b"},     32'(mac_b),     0);
      chk({tag, "_mac_sum"},   32'(mac_sum),   0);
      chk({tag, "_res_data"},  32'(res_data),  0);
   endtask

   task automatic run_pass(input vec_t v);
      int cyc;
      int nce;
      int nrd;
      logic [N-1:0] held;
      logic [N-1:0] want;
      base_act = v.ba;
      base_wgt = v.bw;
      bias     = v.bias;
      start    = 1'b1;
      sb_q.push_back(v.exp);
      @(posedge clk); #1;
      start = 1'b0;
      cyc = 1;
      nce = 0;
      nrd = 0;
      chk("busy_rise", 32'(busy), 1);
      chk("idle_operands", 32'({mac_a, mac_sum}), 0);
      while (!res_valid && cyc < 40) begin
         if (buf_rd) begin
            chk("act_addr_seq", 32'(act_addr), 32'(AW'(v.ba + AW'(nrd))));
            chk("wgt_addr_seq", 32'(wgt_addr), 32'(AW'(v.bw + AW'(nrd))));
            nrd++;
         end
         if (mac_ce) begin
            if (nce == 0) chk("first_sum_bias", 32'(mac_sum), 32'(v.bias));
            nce++;
         end
         @(posedge clk); #1;
         cyc++;
      end
      chk("valid_latency", cyc, TAPS + 3);
      chk("buf_rd_count", nrd, TAPS);
      chk("mac_ce_count", nce, TAPS);
      held = res_data;
      for (int s = 0; s < v.stall; s++) begin
         start = (s == 1);
         @(posedge clk); #1;
         start = 1'b0;
         chk("hold_data", 32'(res_data), 32'(held));
         chk("hold_valid", 32'(res_valid), 1);
         chk("hold_busy", 32'(busy), 1);
      end
      res_ready = 1'b1;
      start     = v.hs_start;
      if (sb_q.size() == 0) begin
         chk("scoreboard_empty", 1, 0);
      end else begin
         want = sb_q.pop_front();
         chk("res_data", 32'(res_data), 32'(want));
      end
      @(posedge clk); #1;
      res_ready = 1'b0;
      chk("post_hs_valid", 32'(res_valid), 0);
      chk("post_hs_busy", 32'(busy), 0);
      if (!v.hs_start) begin
         @(posedge clk); #1;
         chk("no_queued_start", 32'({busy, buf_rd}), 0);
      end
   endtask

   initial begin
      for (int k = 0; k < 256; k++) begin
         act_mem[k] = '0;
         wgt_mem[k] = '0;
      end
      for (int k = 0; k < TAPS; k++) begin
         act_mem[8'h10 + k] = 16'(k + 1);
         act_mem[8'h30 + k] = 16'hFFFF;
         act_mem[8'(8'hFE + k)] = 16'd2;
         wgt_mem[8'h40 + k] = 16'd1;
         wgt_mem[8'h50 + k] = 16'(k + 1);
         wgt_mem[8'h60 + k] = 16'd3;
      end

      vecs[0] = '{ba: 8'h10, bw: 8'h40, bias: 16'd5,    stall: 0, hs_start: 1'b0, exp: 16'h0032};
`ifdef MAC_FEED_RELU_EN
      vecs[1] = '{ba: 8'h20, bw: 8'h50, bias: 16'hFF9C, stall: 5, hs_start: 1'b0, exp: 16'h0000};
      vecs[4] = '{ba: 8'h30, bw: 8'h40, bias: 16'h0000, stall: 0, hs_start: 1'b0, exp: 16'h0000};
`else
      vecs[1] = '{ba: 8'h20, bw: 8'h50, bias: 16'hFF9C, stall: 5, hs_start: 1'b0, exp: 16'hFF9C};
      vecs[4] = '{ba: 8'h30, bw: 8'h40, bias: 16'h0000, stall: 0, hs_start: 1'b0, exp: 16'hFFF7};
`endif
      vecs[2] = '{ba: 8'h10, bw: 8'h50, bias: 16'h0000, stall: 0, hs_start: 1'b1, exp: 16'h011D};
      vecs[3] = '{ba: 8'hFE, bw: 8'h60, bias: 16'h0001, stall: 0, hs_start: 1'b0, exp: 16'h0037};
      vecs[5] = '{ba: 8'h30, bw: 8'h40, bias: 16'h0010, stall: 0, hs_start: 1'b0, exp: 16'h0007};

      repeat (3) @(posedge clk);
      #1;
      chk_all_zero("reset");
      rst = 1'b1;
      @(posedge clk); #1;

      for (int i = 0; i < 6; i++) run_pass(vecs[i]);

      // Abort a pass in its fourth ISSUE cycle, then rerun it cleanly.
      base_act = 8'h10;
      base_wgt = 8'h40;
      bias     = 16'd5;
      start    = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      repeat (3) begin
         @(posedge clk); #1;
      end
      chk("pre_reset_ce", 32'(mac_ce), 1);
      rst = 1'b0;
      #1;
      chk_all_zero("mid_reset");
      @(posedge clk); #1;
      rst = 1'b1;
      @(posedge clk); #1;
      run_pass(vecs[0]);

      chk("scoreboard_drained", sb_q.size(), 0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
